rom_stream_reader: RTL and testbench

Sequential read initiator for the single-port synchronous ROM (one-cycle registered read, high-impedance data when not enabled). On a start command it walks a contiguous address range, drives the ROM's address and enable, captures each returned word, and presents the words as a valid/ready stream with a last marker. It sits between the ROM and any consumer that needs table or microcode contents streamed out under backpressure.

---
 rtl/rom_stream_reader.sv | 132 +++++++++++++
 tb/tb_rom_stream_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Walks a contiguous ROM address range and streams the returned words out as a
// valid/ready stream with a last marker, under consumer backpressure.
module rom_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_enable,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    // state  | meaning
    // IDLE   | waiting for start; base/length captured on start
    // READ   | issuing ROM reads while credit allows
    // DRAIN  | all reads issued; waiting for the last word to be accepted
    // FINISH | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                       state;
    logic [LEN_WIDTH-1:0]         len_q;
    logic [LEN_WIDTH-1:0]         issued;
    logic [LEN_WIDTH-1:0]         accepted;
    logic                         in_flight;
    logic                         in_flight_last;
    logic [1:0][DATA_WIDTH-1:0]   buf_data;
    logic [1:0]                   buf_last;
    logic                         rd_ptr;
    logic                         wr_ptr;
    logic [1:0]                   count;
    logic [1:0]                   credit;
    logic                         pop;
    logic                         issue;
    logic                         issue_last;

    // credit is also next-cycle occupancy: the in-flight word always lands next cycle
    always_comb begin
        m_valid    = (count != 2'd0);
        m_data     = buf_data[rd_ptr];
        m_last     = m_valid & buf_last[rd_ptr];
        pop        = m_valid & m_ready;
        credit     = count + {1'b0, in_flight} - {1'b0, pop};
        issue      = (state == READ) && (issued != len_q) && (credit < 2'd2);
        issue_last = (issued == len_q - LEN_WIDTH'(1));
        rom_enable = issue;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            rom_addr       <= '0;
            len_q          <= '0;
            issued         <= '0;
            accepted       <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            buf_data       <= '0;
            buf_last       <= '0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            count          <= 2'd0;
        end else begin
            in_flight      <= issue;
            in_flight_last <= issue & issue_last;
            if (issue) begin
                rom_addr <= rom_addr + ADDR_WIDTH'(1);
                issued   <= issued + LEN_WIDTH'(1);
            end
            // rom_data is only meaningful the cycle after an enabled read
            if (in_flight) begin
                buf_data[wr_ptr] <= rom_data;
                buf_last[wr_ptr] <= in_flight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                accepted <= accepted + LEN_WIDTH'(1);
            end
            count <= credit;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= length;
                        rom_addr <= base_addr;
                        issued   <= '0;
                        accepted <= '0;
                        if (length == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue && issue_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && (accepted == len_q - LEN_WIDTH'(1))) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: a ROM model plus a per-transfer expected-beat
// queue built straight from base/length, checked beat by beat.
module tb_rom_stream_reader;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, rom_enable, m_valid, m_last;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data, m_data;

    always #5 clk = ~clk;

    rom_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .rom_addr(rom_addr),
        .rom_enable(rom_enable), .rom_data(rom_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    // ROM: one-cycle registered read; a poison word stands in for the floating bus
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rom_q = '0;
    logic          rom_vld = 1'b0;
    always @(posedge clk) begin
        rom_vld <= rom_enable;
        if (rom_enable) rom_q <= mem[rom_addr];
    end
    assign rom_data = rom_vld ? rom_q : 32'hBAD0_BAD0;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic [7:0] base;
        int         len;
        int         mode;      // 0: ready=1, 1: fixed toggle pattern, 2: random
        int         exp_done;  // expected done cycle, -1 when not fixed
        int         poke;      // cycle to pulse a stray start, -1 for none
    } vec_t;

    int tests = 0;
    int fails = 0;

    beat_t      exp_q[$];
    logic [7:0] base_cur;
    int         len_cur, cyc, n_issue, n_acc, n_done, done_cyc;
    int         first_en, last_en, first_beat, last_beat;
    int         addr_err, busy_err, stab_err, ovf_err;
    logic       prev_stall;
    logic [31:0] prev_data;
    logic       prev_last;
    bit         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[c % 6];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic begin_xfer(input logic [7:0] base, input int len);
        logic [7:0] a;
        base_cur = base; len_cur = len;
        n_issue = 0; n_acc = 0; n_done = 0; done_cyc = -1;
        first_en = -1; last_en = -1; first_beat = -1; last_beat = -1;
        addr_err = 0; busy_err = 0; stab_err = 0; ovf_err = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            a = base + 8'(i);
            exp_q.push_back('{d: mem[a], l: (i == len - 1)});
        end
    endtask

    task automatic sample_cycle();
        beat_t      b;
        logic       exp_busy;
        logic [7:0] ea;
        if (rom_enable) begin
            ea = base_cur + 8'(n_issue);
            if (rom_addr !== ea || n_issue >= len_cur) addr_err++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            n_issue++;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", longint'(m_data), longint'(b.d));
                check("beat_last", longint'(m_last), longint'(b.l));
            end
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            n_acc++;
        end
        if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_err++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (n_issue - n_acc > 2) ovf_err++;
        exp_busy = (len_cur > 0) && (cyc >= 1) && (n_done == 0) && !done;
        if (busy !== exp_busy) busy_err++;
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
    endtask

    task automatic finish_checks(input int mode, input int exp_done);
        if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
        check("reads", n_issue, len_cur);
        check("beats", n_acc, len_cur);
        check("addr_seq", addr_err, 0);
        check("busy", busy_err, 0);
        check("stall_hold", stab_err, 0);
        check("credit", ovf_err, 0);
        if (mode == 0 && len_cur > 0) begin
            check("first_en", first_en, 1);
            check("last_en", last_en, len_cur);
            check("first_beat", first_beat, 3);
            check("last_beat", last_beat, len_cur + 2);
        end
    endtask

    task automatic run_xfer(input logic [7:0] base, input int len, input int mode,
                            input int exp_done, input int poke);
        bit timed_out = 0;
        @(posedge clk); #1;
        begin_xfer(base, len);
        cyc       = 0;
        base_addr = base;
        length    = LW'(len);
        start     = 1'b1;
        m_ready   = ready_for(mode, 0);
        @(negedge clk);
        sample_cycle();
        while (n_done == 0) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == poke);
            if (cyc == poke) begin
                base_addr = 8'h77;
                length    = LW'(9);
            end
            m_ready = ready_for(mode, cyc);
            @(negedge clk);
            sample_cycle();
            if (cyc > 3000) begin
                timed_out = 1;
                break;
            end
        end
        start = 1'b0;
        if (timed_out) check("done_timeout", 1, 0);
        finish_checks(mode, exp_done);
    endtask

    vec_t vecs [9];
    int   rst_err;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), 24'($urandom)};
        mem[0] = 32'hDEADBEEF;
        mem[1] = 32'h12345678;
        mem[2] = 32'hABCDEF01;

        vecs[0] = '{base: 8'h00, len: 3,   mode: 0, exp_done: 6,   poke: -1};
        vecs[1] = '{base: 8'hFE, len: 4,   mode: 0, exp_done: 7,   poke: -1};
        vecs[2] = '{base: 8'h00, len: 3,   mode: 1, exp_done: -1,  poke: -1};
        vecs[3] = '{base: 8'h10, len: 0,   mode: 0, exp_done: 1,   poke: -1};
        vecs[4] = '{base: 8'h20, len: 5,   mode: 0, exp_done: 8,   poke: 2};
        vecs[5] = '{base: 8'h0A, len: 1,   mode: 0, exp_done: 4,   poke: -1};
        vecs[6] = '{base: 8'h00, len: 256, mode: 0, exp_done: 259, poke: -1};
        vecs[7] = '{base: 8'h40, len: 17,  mode: 2, exp_done: -1,  poke: -1};
        vecs[8] = '{base: 8'hF0, len: 30,  mode: 1, exp_done: -1,  poke: -1};

        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", longint'({busy, done, rom_enable, m_valid, m_last, rom_addr, m_data}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++)
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].exp_done, vecs[v].poke);

        // reset in the middle of a transfer, after two accepted beats
        @(posedge clk); #1;
        begin_xfer(8'h30, 5);
        cyc = 0; base_addr = 8'h30; length = LW'(5); start = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        sample_cycle();
        while (n_acc < 2 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            @(negedge clk);
            sample_cycle();
        end
        check("beats_before_reset", n_acc, 2);
        check("en_before_reset", longint'(rom_enable), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", longint'({busy, done, rom_enable, m_valid, m_last, rom_addr, m_data}), 0);
        rst_err = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if ({busy, done, rom_enable, m_valid, m_last} !== 5'b0) rst_err++;
        end
        check("reset_hold", rst_err, 0);
        rst_n = 1'b1;
        run_xfer(8'h50, 4, 0, 7, -1);

        for (int r = 0; r < 6; r++)
            run_xfer(8'($urandom_range(0, 255)), int'($urandom_range(0, 40)), 2, -1, -1);

        @(negedge clk);
        check("done_single_pulse", longint'(done), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
